// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame checker.
// Holds the FSM state encoding and the default frame length limit.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam int DEFAULT_MAX_LEN = 16;

    // Even-parity style check: the frame is good when the running XOR is zero.
    function automatic logic xor_is_zero(input logic [7:0] value);
        return (value == 8'h00);
    endfunction

endpackage

// File: rtl/parity_frame_checker_sat_counter8.sv
// 8-bit saturating up-counter with increment enable.
// Cleared asynchronously by rst_n and synchronously by i_srst.
module sat_counter8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_srst,
    input  logic       i_inc,
    output logic [7:0] o_count
);

    logic [7:0] r_count;

    // Count register: holds at 0xFF once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_srst) begin
            r_count <= 8'd0;
        end else if (i_inc && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/parity_frame_checker.sv
// Accumulates the XOR of each byte frame and reports pass/fail, length and
// overflow through a valid/ready result port; oversize frames are drained.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_ok,
    output logic       res_ovf,
    output logic [7:0] res_len,
    output logic [7:0] err_count
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_acc;
    logic [7:0] r_len;
    logic       r_res_valid;
    logic       r_in_ready;
    logic       r_res_ok;
    logic       r_res_ovf;
    logic [7:0] r_res_len;

    logic [7:0] w_acc_nxt;
    logic [7:0] w_len_nxt;
    logic       w_ok_nxt;
    logic       w_ovf_nxt;
    logic [7:0] w_res_len_nxt;
    logic       w_accept;
    logic [7:0] w_acc_x;
    logic [7:0] w_len_inc;
    logic       w_res_hs;
    logic       w_err_inc;

    assign w_accept  = in_valid && r_in_ready;
    assign w_acc_x   = r_acc ^ in_data;
    assign w_len_inc = r_len + 8'd1;
    assign w_res_hs  = r_res_valid && res_ready;
    assign w_err_inc = w_res_hs && !r_res_ok;

    // Next-state and next-result computation for the frame FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_len_nxt     = r_len;
        w_ok_nxt      = r_res_ok;
        w_ovf_nxt     = r_res_ovf;
        w_res_len_nxt = r_res_len;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_state_nxt   = ST_REPORT;
                        w_ok_nxt      = xor_is_zero(in_data);
                        w_ovf_nxt     = 1'b0;
                        w_res_len_nxt = 8'd1;
                        w_acc_nxt     = in_data;
                        w_len_nxt     = 8'd1;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                        w_acc_nxt   = in_data;
                        w_len_nxt   = 8'd1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = w_acc_x;
                    w_len_nxt = w_len_inc;
                    // A check byte landing exactly on MAX_LEN is a legal frame.
                    if (in_last) begin
                        w_state_nxt   = ST_REPORT;
                        w_ok_nxt      = xor_is_zero(w_acc_x);
                        w_ovf_nxt     = 1'b0;
                        w_res_len_nxt = w_len_inc;
                    end else if (w_len_inc == MAX_LEN_B) begin
                        w_state_nxt   = ST_REPORT;
                        w_ok_nxt      = 1'b0;
                        w_ovf_nxt     = 1'b1;
                        w_res_len_nxt = MAX_LEN_B;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    w_state_nxt = r_res_ovf ? ST_DRAIN : ST_IDLE;
                    w_acc_nxt   = 8'd0;
                    w_len_nxt   = 8'd0;
                end else begin
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_DRAIN: begin
                if (w_accept && in_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_acc_nxt   = 8'd0;
                w_len_nxt   = 8'd0;
            end
        endcase
    end

    // State, accumulator and registered result/handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= 8'd0;
            r_len       <= 8'd0;
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_res_ok    <= 1'b0;
            r_res_ovf   <= 1'b0;
            r_res_len   <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_len       <= w_len_nxt;
            r_res_valid <= (w_state_nxt == ST_REPORT);
            r_in_ready  <= (w_state_nxt != ST_REPORT);
            r_res_ok    <= w_ok_nxt;
            r_res_ovf   <= w_ovf_nxt;
            r_res_len   <= w_res_len_nxt;
        end
    end

    sat_counter8 u_err_count (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_srst  (1'b0),
        .i_inc   (w_err_inc),
        .o_count (err_count)
    );

    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign res_ok    = r_res_ok;
    assign res_ovf   = r_res_ovf;
    assign res_len   = r_res_len;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed self-checking bench for parity_frame_checker (MAX_LEN = 4).
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       res_valid;
    logic       res_ready;
    logic       res_ok;
    logic       res_ovf;
    logic [7:0] res_len;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    parity_frame_checker #(.MAX_LEN(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ok    (res_ok),
        .res_ovf   (res_ovf),
        .res_len   (res_len),
        .err_count (err_count)
    );

    // Present one byte for exactly one rising edge, sample point is #1 after it.
    task automatic send_byte(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; res_ready = 1'b0;
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if ({res_valid, res_ok, res_ovf, res_len, err_count, in_ready} !== {3'b000, 8'd0, 8'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b ok=%b ovf=%b len=%0d err=%0d rdy=%b want 0 0 0 0 0 1",
                     res_valid, res_ok, res_ovf, res_len, err_count, in_ready);
        end
        reset_n = 1'b1;
        // Reset during REPORT drops the pending result.
        send_byte(8'h00, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, res_ok, res_len} !== {1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_in_report: got v=%b ok=%b len=%0d want 0 0 0", res_valid, res_ok, res_len);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_result: got res_valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_good_frame();
        do_reset();
        res_ready = 1'b1;
        send_byte(8'h12, 1'b0);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL good_midframe_valid: got %b want 0", res_valid);
        end
        send_byte(8'h34, 1'b0);
        send_byte(8'h26, 1'b1);
        n_cmp++;
        if ({res_valid, res_ok, res_ovf, res_len} !== {3'b110, 8'd3}) begin
            n_err++;
            $display("FAIL good_result: got v=%b ok=%b ovf=%b len=%0d want 1 1 0 3",
                     res_valid, res_ok, res_ovf, res_len);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({res_valid, err_count} !== {1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL good_after_hs: got v=%b err=%0d want 0 0", res_valid, err_count);
        end
    endtask

    task automatic test_bad_frame();
        do_reset();
        res_ready = 1'b1;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h00, 1'b1);
        n_cmp++;
        if ({res_valid, res_ok, res_ovf, res_len} !== {3'b100, 8'd3}) begin
            n_err++;
            $display("FAIL bad_result: got v=%b ok=%b ovf=%b len=%0d want 1 0 0 3",
                     res_valid, res_ok, res_ovf, res_len);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (err_count !== 8'd1) begin
            n_err++;
            $display("FAIL bad_err_count: got %0d want 1", err_count);
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        res_ready = 1'b1;
        send_byte(8'h00, 1'b1);
        n_cmp++;
        if ({res_valid, res_ok, res_len} !== {2'b11, 8'd1}) begin
            n_err++;
            $display("FAIL single_zero: got v=%b ok=%b len=%0d want 1 1 1", res_valid, res_ok, res_len);
        end
        @(posedge clk); #1;
        send_byte(8'h5A, 1'b1);
        n_cmp++;
        if ({res_valid, res_ok, res_len} !== {2'b10, 8'd1}) begin
            n_err++;
            $display("FAIL single_5a: got v=%b ok=%b len=%0d want 1 0 1", res_valid, res_ok, res_len);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (err_count !== 8'd1) begin
            n_err++;
            $display("FAIL single_err_count: got %0d want 1", err_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        res_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        n_cmp++;
        if ({res_valid, res_ok, res_ovf, res_len} !== {3'b101, 8'd4}) begin
            n_err++;
            $display("FAIL ovf_result: got v=%b ok=%b ovf=%b len=%0d want 1 0 1 4",
                     res_valid, res_ok, res_ovf, res_len);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 5; i <= 6; i++) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_drain_ready: byte %0d got in_ready=%b want 1", i, in_ready);
            end
            send_byte(8'(i), (i == 6) ? 1'b1 : 1'b0);
            n_cmp++;
            if (res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL ovf_drain_novalid: byte %0d got res_valid=%b want 0", i, res_valid);
            end
        end
        send_byte(8'h0F, 1'b0);
        send_byte(8'h0F, 1'b1);
        n_cmp++;
        if ({res_valid, res_ok, res_ovf, res_len, err_count} !== {3'b110, 8'd2, 8'd1}) begin
            n_err++;
            $display("FAIL ovf_next_frame: got v=%b ok=%b ovf=%b len=%0d err=%0d want 1 1 0 2 1",
                     res_valid, res_ok, res_ovf, res_len, err_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        do_reset();
        res_ready = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h11, 1'b1);
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({res_valid, res_ok, res_ovf, res_len, in_ready} !== {3'b110, 8'd2, 1'b0}) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got v=%b ok=%b ovf=%b len=%0d rdy=%b want 1 1 0 2 0",
                         c, res_valid, res_ok, res_ovf, res_len, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        res_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({res_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_release: got v=%b rdy=%b want 0 1", res_valid, in_ready);
        end
        send_byte(8'h05, 1'b1);
        n_cmp++;
        if ({res_valid, res_ok, res_len} !== {2'b10, 8'd1}) begin
            n_err++;
            $display("FAIL hold_next: got v=%b ok=%b len=%0d want 1 0 1", res_valid, res_ok, res_len);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        res_ready = 1'b1;
        send_byte(8'h5A, 1'b1);
        @(posedge clk); #1;
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, res_ok, res_ovf, res_len, err_count} !== {3'b000, 8'd0, 8'd0}) begin
            n_err++;
            $display("FAIL midframe_reset: got v=%b ok=%b ovf=%b len=%0d err=%0d want all 0",
                     res_valid, res_ok, res_ovf, res_len, err_count);
        end
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hAA, 1'b1);
        n_cmp++;
        if ({res_valid, res_ok, res_ovf, res_len} !== {3'b110, 8'd2}) begin
            n_err++;
            $display("FAIL midframe_next: got v=%b ok=%b ovf=%b len=%0d want 1 1 0 2",
                     res_valid, res_ok, res_ovf, res_len);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_single_byte();
        test_overflow();
        test_backpressure();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
